// File: rtl/fifo_ctrl_if.sv
// fifo_ctrl_if: bundles the request, threshold and status signals of the FIFO
// pointer/flag controller.
//   master modport: the traffic source/sink side. It drives init, push, pop and
//                   the two thresholds, and observes strobes, pointers, count,
//                   flags and state.
//   slave  modport: the fifo_ctrl block itself. It observes the requests and
//                   drives the memory strobes, pointers and status.
interface fifo_ctrl_if #(
    parameter int MAIN_SIZE = 4,
    parameter int CNT_SIZE  = MAIN_SIZE + 1
);
    logic                 init;
    logic                 push;
    logic                 pop;
    logic [CNT_SIZE-1:0]  th_almost_full;
    logic [CNT_SIZE-1:0]  th_almost_empty;
    logic                 write;
    logic                 read;
    logic [MAIN_SIZE-1:0] wr_ptr;
    logic [MAIN_SIZE-1:0] rd_ptr;
    logic [CNT_SIZE-1:0]  count;
    logic                 full;
    logic                 empty;
    logic                 almost_full;
    logic                 almost_empty;
    logic                 error;
    logic [2:0]           state;

    modport master (
        output init, push, pop, th_almost_full, th_almost_empty,
        input  write, read, wr_ptr, rd_ptr, count,
        input  full, empty, almost_full, almost_empty, error, state
    );

    modport slave (
        input  init, push, pop, th_almost_full, th_almost_empty,
        output write, read, wr_ptr, rd_ptr, count,
        output full, empty, almost_full, almost_empty, error, state
    );
endinterface

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer, occupancy and flag controller for the 4x8 dual-pointer
// FIFO memory. It turns push/pop requests into memory write/read strobes and
// addresses, tracks occupancy, derives full/empty/almost flags against
// thresholds latched during INIT, and runs a RESET/INIT/IDLE/ACTIVE/ERROR
// state machine so upstream flow control can gate traffic on FIFO health.
// Ports:
//   clk   - single clock, all state updates on the rising edge
//   reset - synchronous, active-high; overrides everything
//   bus   - fifo_ctrl_if.slave: init/push/pop/thresholds in; write/read,
//           wr_ptr/rd_ptr, count, full/empty/almost_full/almost_empty, error
//           and state out
module fifo_ctrl #(
    parameter int MAIN_SIZE = 4,
    parameter int DEPTH     = 4,
    parameter int CNT_SIZE  = MAIN_SIZE + 1
) (
    input  logic        clk,
    input  logic        reset,
    fifo_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        ST_RESET  = 3'b000,
        ST_INIT   = 3'b001,
        ST_IDLE   = 3'b010,
        ST_ACTIVE = 3'b011,
        ST_ERROR  = 3'b100
    } state_t;

    localparam logic [CNT_SIZE-1:0]  DEPTH_CNT = CNT_SIZE'(DEPTH);
    localparam logic [MAIN_SIZE-1:0] LAST_PTR  = MAIN_SIZE'(DEPTH - 1);

    state_t               state_q;
    logic [MAIN_SIZE-1:0] wr_ptr_q;
    logic [MAIN_SIZE-1:0] rd_ptr_q;
    logic [CNT_SIZE-1:0]  count_q;
    logic [CNT_SIZE-1:0]  count_next;
    logic [CNT_SIZE-1:0]  th_af_q;
    logic [CNT_SIZE-1:0]  th_ae_q;
    logic                 error_q;
    logic                 accepting;
    logic                 full_w;
    logic                 empty_w;
    logic                 write_w;
    logic                 read_w;
    logic                 overflow;
    logic                 underflow;

    // Pointers wrap at the real memory depth, which may be smaller than the
    // address space.
    function automatic logic [MAIN_SIZE-1:0] next_ptr(input logic [MAIN_SIZE-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Requests are only honoured in IDLE/ACTIVE. A push into a full FIFO or a
    // pop from an empty one is rejected and flagged, while the other half of a
    // simultaneous request still goes through.
    always_comb begin
        accepting  = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
        full_w     = (count_q == DEPTH_CNT);
        empty_w    = (count_q == '0);
        write_w    = accepting && bus.push && !full_w;
        read_w     = accepting && bus.pop  && !empty_w;
        overflow   = accepting && bus.push && full_w;
        underflow  = accepting && bus.pop  && empty_w;
        count_next = count_q;
        if (write_w && !read_w) begin
            count_next = count_q + 1'b1;
        end else if (read_w && !write_w) begin
            count_next = count_q - 1'b1;
        end
    end

    // Single state machine that owns pointers, count, thresholds and the
    // sticky error. An accepted op in the same cycle as an overflow/underflow
    // still lands before the block freezes in ERROR.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_RESET;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            error_q  <= 1'b0;
            th_af_q  <= DEPTH_CNT - 1'b1;
            th_ae_q  <= CNT_SIZE'(1);
        end else begin
            if (write_w) begin
                wr_ptr_q <= next_ptr(wr_ptr_q);
            end
            if (read_w) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            count_q <= count_next;
            case (state_q)
                ST_RESET: begin
                    state_q <= ST_INIT;
                end
                ST_INIT: begin
                    th_af_q <= bus.th_almost_full;
                    th_ae_q <= bus.th_almost_empty;
                    if (!bus.init) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_IDLE, ST_ACTIVE: begin
                    if (overflow || underflow) begin
                        state_q <= ST_ERROR;
                        error_q <= 1'b1;
                    end else if (count_next == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_ACTIVE;
                    end
                end
                ST_ERROR: begin
                    state_q <= ST_ERROR;
                end
                default: begin
                    state_q <= ST_ERROR;
                    error_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.write        = write_w;
    assign bus.read         = read_w;
    assign bus.wr_ptr       = wr_ptr_q;
    assign bus.rd_ptr       = rd_ptr_q;
    assign bus.count        = count_q;
    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (count_q >= th_af_q);
    assign bus.almost_empty = (count_q <= th_ae_q);
    assign bus.error        = error_q;
    assign bus.state        = state_q;
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed test of fifo_ctrl with hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// (registered values) or 1 time unit after an input change (strobes).
module tb_fifo_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   compared   = 0;
    int   mismatched = 0;

    fifo_ctrl_if #(.MAIN_SIZE(4), .CNT_SIZE(5)) bus ();

    fifo_ctrl #(.MAIN_SIZE(4), .DEPTH(4), .CNT_SIZE(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and return on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reset, pass through INIT with the given thresholds, end in IDLE.
    task automatic bring_up(input logic [4:0] af, input logic [4:0] ae);
        reset = 1'b1; bus.init = 1'b0; bus.push = 1'b0; bus.pop = 1'b0;
        step();
        reset = 1'b0; bus.init = 1'b1;
        bus.th_almost_full = af; bus.th_almost_empty = ae;
        step();
        bus.init = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.init = 1'b0; bus.push = 1'b1; bus.pop = 1'b0;
        bus.th_almost_full = 5'd3; bus.th_almost_empty = 5'd1;
        step(); step();
        compared++; if (bus.state !== 3'b000) begin mismatched++; $display("[TB] FAIL reset_state: got %0d expected 0", bus.state); end
        compared++; if (bus.count !== 5'd0) begin mismatched++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.count); end
        compared++; if (bus.wr_ptr !== 4'd0 || bus.rd_ptr !== 4'd0) begin mismatched++; $display("[TB] FAIL reset_ptrs: got wr=%0d rd=%0d expected 0/0", bus.wr_ptr, bus.rd_ptr); end
        compared++; if ({bus.empty, bus.almost_empty, bus.full, bus.almost_full} !== 4'b1100) begin mismatched++; $display("[TB] FAIL reset_flags: got e/ae/f/af=%b expected 1100", {bus.empty, bus.almost_empty, bus.full, bus.almost_full}); end
        compared++; if (bus.error !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_error: got %b expected 0", bus.error); end
        compared++; if (bus.write !== 1'b0 || bus.read !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_strobes: got w=%b r=%b expected 0/0", bus.write, bus.read); end
        bus.push = 1'b0; reset = 1'b0; bus.init = 1'b1;
        step();
        compared++; if (bus.state !== 3'b001) begin mismatched++; $display("[TB] FAIL init_state: got %0d expected 1", bus.state); end
        bus.push = 1'b1; #1;
        compared++; if (bus.write !== 1'b0) begin mismatched++; $display("[TB] FAIL init_write_ignored: got %b expected 0", bus.write); end
        step();
        compared++; if (bus.state !== 3'b001 || bus.error !== 1'b0) begin mismatched++; $display("[TB] FAIL init_hold: got state=%0d err=%b expected 1/0", bus.state, bus.error); end
        bus.push = 1'b0; bus.init = 1'b0;
        step();
        compared++; if (bus.state !== 3'b010) begin mismatched++; $display("[TB] FAIL idle_state: got %0d expected 2", bus.state); end
        compared++; if (bus.count !== 5'd0 || bus.empty !== 1'b1) begin mismatched++; $display("[TB] FAIL idle_empty: got count=%0d empty=%b expected 0/1", bus.count, bus.empty); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            bus.push = 1'b1; #1;
            compared++; if (bus.write !== 1'b1 || bus.wr_ptr !== 4'(i)) begin mismatched++; $display("[TB] FAIL fill_write[%0d]: got w=%b ptr=%0d expected 1/%0d", i, bus.write, bus.wr_ptr, i); end
            step();
            compared++; if (bus.count !== 5'(i + 1)) begin mismatched++; $display("[TB] FAIL fill_count[%0d]: got %0d expected %0d", i, bus.count, i + 1); end
            compared++; if (bus.almost_full !== ((i + 1) >= 3) || bus.full !== ((i + 1) == 4)) begin mismatched++; $display("[TB] FAIL fill_flags[%0d]: got af=%b f=%b expected %b/%b", i, bus.almost_full, bus.full, ((i + 1) >= 3), ((i + 1) == 4)); end
            compared++; if (bus.state !== 3'b011) begin mismatched++; $display("[TB] FAIL fill_state[%0d]: got %0d expected 3", i, bus.state); end
        end
        bus.push = 1'b0;
        compared++; if (bus.wr_ptr !== 4'd0) begin mismatched++; $display("[TB] FAIL fill_wrap: got %0d expected 0", bus.wr_ptr); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 4; i++) begin
            bus.pop = 1'b1; #1;
            compared++; if (bus.read !== 1'b1 || bus.rd_ptr !== 4'(i)) begin mismatched++; $display("[TB] FAIL drain_read[%0d]: got r=%b ptr=%0d expected 1/%0d", i, bus.read, bus.rd_ptr, i); end
            step();
            compared++; if (bus.count !== 5'(3 - i)) begin mismatched++; $display("[TB] FAIL drain_count[%0d]: got %0d expected %0d", i, bus.count, 3 - i); end
            compared++; if (bus.almost_empty !== ((3 - i) <= 1) || bus.empty !== ((3 - i) == 0)) begin mismatched++; $display("[TB] FAIL drain_flags[%0d]: got ae=%b e=%b expected %b/%b", i, bus.almost_empty, bus.empty, ((3 - i) <= 1), ((3 - i) == 0)); end
        end
        bus.pop = 1'b0;
        compared++; if (bus.state !== 3'b010 || bus.rd_ptr !== 4'd0) begin mismatched++; $display("[TB] FAIL drain_end: got state=%0d rd=%0d expected 2/0", bus.state, bus.rd_ptr); end
    endtask

    task automatic test_back_to_back();
        bus.push = 1'b1;
        step(); step();
        bus.push = 1'b0;
        compared++; if (bus.count !== 5'd2 || bus.wr_ptr !== 4'd2) begin mismatched++; $display("[TB] FAIL b2b_setup: got count=%0d wr=%0d expected 2/2", bus.count, bus.wr_ptr); end
        bus.push = 1'b1; bus.pop = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            compared++; if (bus.write !== 1'b1 || bus.read !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_strobes[%0d]: got w=%b r=%b expected 1/1", i, bus.write, bus.read); end
            compared++; if (bus.wr_ptr !== 4'((2 + i) % 4) || bus.rd_ptr !== 4'(i % 4)) begin mismatched++; $display("[TB] FAIL b2b_ptrs[%0d]: got wr=%0d rd=%0d expected %0d/%0d", i, bus.wr_ptr, bus.rd_ptr, (2 + i) % 4, i % 4); end
            step();
            compared++; if (bus.count !== 5'd2 || bus.state !== 3'b011) begin mismatched++; $display("[TB] FAIL b2b_count[%0d]: got count=%0d state=%0d expected 2/3", i, bus.count, bus.state); end
        end
        bus.push = 1'b0; bus.pop = 1'b0;
    endtask

    task automatic test_overflow();
        bus.push = 1'b1;
        step(); step();
        bus.push = 1'b0;
        compared++; if (bus.count !== 5'd4 || bus.full !== 1'b1 || bus.wr_ptr !== 4'd2) begin mismatched++; $display("[TB] FAIL ovf_setup: got count=%0d full=%b wr=%0d expected 4/1/2", bus.count, bus.full, bus.wr_ptr); end
        bus.push = 1'b1; #1;
        compared++; if (bus.write !== 1'b0) begin mismatched++; $display("[TB] FAIL ovf_write: got %b expected 0", bus.write); end
        step();
        compared++; if (bus.error !== 1'b1 || bus.state !== 3'b100) begin mismatched++; $display("[TB] FAIL ovf_error: got err=%b state=%0d expected 1/4", bus.error, bus.state); end
        bus.pop = 1'b1; #1;
        compared++; if (bus.write !== 1'b0 || bus.read !== 1'b0) begin mismatched++; $display("[TB] FAIL err_strobes: got w=%b r=%b expected 0/0", bus.write, bus.read); end
        step(); step();
        compared++; if (bus.count !== 5'd4 || bus.wr_ptr !== 4'd2 || bus.rd_ptr !== 4'd2 || bus.state !== 3'b100) begin mismatched++; $display("[TB] FAIL err_frozen: got count=%0d wr=%0d rd=%0d state=%0d expected 4/2/2/4", bus.count, bus.wr_ptr, bus.rd_ptr, bus.state); end
        bus.push = 1'b0; bus.pop = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        compared++; if (bus.state !== 3'b000 || bus.error !== 1'b0 || bus.count !== 5'd0) begin mismatched++; $display("[TB] FAIL err_reset: got state=%0d err=%b count=%0d expected 0/0/0", bus.state, bus.error, bus.count); end
    endtask

    task automatic test_underflow();
        bring_up(5'd3, 5'd1);
        bus.pop = 1'b1; #1;
        compared++; if (bus.read !== 1'b0) begin mismatched++; $display("[TB] FAIL udf_read: got %b expected 0", bus.read); end
        step();
        bus.pop = 1'b0;
        compared++; if (bus.error !== 1'b1 || bus.state !== 3'b100 || bus.count !== 5'd0) begin mismatched++; $display("[TB] FAIL udf_error: got err=%b state=%0d count=%0d expected 1/4/0", bus.error, bus.state, bus.count); end
    endtask

    task automatic test_simultaneous_edges();
        bring_up(5'd3, 5'd1);
        bus.push = 1'b1; bus.pop = 1'b1; #1;
        compared++; if (bus.write !== 1'b1 || bus.read !== 1'b0) begin mismatched++; $display("[TB] FAIL sim_empty_strobes: got w=%b r=%b expected 1/0", bus.write, bus.read); end
        step();
        bus.push = 1'b0; bus.pop = 1'b0;
        compared++; if (bus.state !== 3'b100 || bus.count !== 5'd1 || bus.wr_ptr !== 4'd1) begin mismatched++; $display("[TB] FAIL sim_empty_result: got state=%0d count=%0d wr=%0d expected 4/1/1", bus.state, bus.count, bus.wr_ptr); end
        bring_up(5'd3, 5'd1);
        bus.push = 1'b1;
        step(); step(); step(); step();
        bus.pop = 1'b1; #1;
        compared++; if (bus.write !== 1'b0 || bus.read !== 1'b1) begin mismatched++; $display("[TB] FAIL sim_full_strobes: got w=%b r=%b expected 0/1", bus.write, bus.read); end
        step();
        bus.push = 1'b0; bus.pop = 1'b0;
        compared++; if (bus.state !== 3'b100 || bus.count !== 5'd3 || bus.rd_ptr !== 4'd1 || bus.error !== 1'b1) begin mismatched++; $display("[TB] FAIL sim_full_result: got state=%0d count=%0d rd=%0d err=%b expected 4/3/1/1", bus.state, bus.count, bus.rd_ptr, bus.error); end
    endtask

    task automatic test_thresholds();
        bring_up(5'd5, 5'd0);
        compared++; if (bus.almost_empty !== 1'b1) begin mismatched++; $display("[TB] FAIL th_ae_empty: got %b expected 1", bus.almost_empty); end
        bus.push = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            compared++; if (bus.almost_full !== 1'b0 || bus.almost_empty !== 1'b0) begin mismatched++; $display("[TB] FAIL th_flags[%0d]: got af=%b ae=%b expected 0/0", i, bus.almost_full, bus.almost_empty); end
        end
        bus.push = 1'b0;
    endtask

    task automatic test_reset_mid();
        bring_up(5'd3, 5'd1);
        bus.push = 1'b1;
        step(); step(); step();
        compared++; if (bus.count !== 5'd3) begin mismatched++; $display("[TB] FAIL mid_setup: got %0d expected 3", bus.count); end
        reset = 1'b1;
        step();
        compared++; if (bus.count !== 5'd0 || bus.wr_ptr !== 4'd0 || bus.rd_ptr !== 4'd0 || bus.empty !== 1'b1 || bus.state !== 3'b000) begin mismatched++; $display("[TB] FAIL mid_reset: got count=%0d wr=%0d rd=%0d empty=%b state=%0d expected 0/0/0/1/0", bus.count, bus.wr_ptr, bus.rd_ptr, bus.empty, bus.state); end
        compared++; if (bus.write !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_write: got %b expected 0", bus.write); end
        bus.push = 1'b0; reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.init = 1'b0; bus.push = 1'b0; bus.pop = 1'b0;
        bus.th_almost_full = 5'd3; bus.th_almost_empty = 5'd1;
        @(negedge clk);
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_overflow();
        test_underflow();
        test_simultaneous_edges();
        test_thresholds();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Pointer, flag and control-state block that sits directly upstream of the 4x8 dual-pointer memory (memory_4x8).
- Turns push/pop requests into the memory's write, read, wr_ptr and rd_ptr.
- Keeps occupancy and generates full, empty, almost_full and almost_empty with programmable thresholds.
- Runs a RESET/INIT/IDLE/ACTIVE/ERROR state machine so flow control in the switch can gate traffic on FIFO health.

Parameters:
MAIN_SIZE, 4, width of wr_ptr/rd_ptr (matches memory address port)
DEPTH, 4, number of memory entries; 2 <= DEPTH <= 2^MAIN_SIZE
CNT_SIZE, MAIN_SIZE+1, width of count and threshold ports

Ports:
clk  input  1  single clock, all state on rising edge
reset  input  1  synchronous, active-high
init  input  1  hold block in INIT and relatch thresholds while high
push  input  1  upstream write request
pop  input  1  downstream read request
th_almost_full  input  CNT_SIZE  almost_full threshold, latched in INIT
th_almost_empty  input  CNT_SIZE  almost_empty threshold, latched in INIT
write  output  1  memory write strobe (accepted push)
read  output  1  memory read strobe (accepted pop)
wr_ptr  output  MAIN_SIZE  memory write address
rd_ptr  output  MAIN_SIZE  memory read address
count  output  CNT_SIZE  current occupancy 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= latched th_almost_full
almost_empty  output  1  count <= latched th_almost_empty
error  output  1  sticky overflow/underflow indication
state  output  3  FSM state encoding

Behaviour:
Reset:
- reset sampled high on a rising edge: state=RESET(3'b000), wr_ptr=rd_ptr=0, count=0, error=0.
- Latched thresholds reset to th_af=DEPTH-1, th_ae=1.
- write=read=0.
- Derived flags out of reset: empty=1, almost_empty=1, full=0, almost_full=0.
- Reset overrides every other input in any state, including mid-transfer.

FSM encoding: RESET=000, INIT=001, IDLE=010, ACTIVE=011, ERROR=100.
- RESET -> INIT on first edge with reset low.
- INIT: thresholds latched from ports every cycle; stays in INIT while init=1; -> IDLE when init=0.
- IDLE: count==0. -> ACTIVE on an accepted push. -> ERROR on pop (underflow).
- ACTIVE: count>0. -> IDLE when the next count is 0. -> ERROR on push while full (overflow). Otherwise stays.
- ERROR: error=1; no push/pop accepted; pointers and count frozen. Exit only via reset.
- In RESET, INIT and ERROR, push/pop are ignored: write=read=0 and no error is raised.

Acceptance (combinational, same cycle as request, only in IDLE/ACTIVE):
- write = push & ~full.
- read = pop & ~empty.
- wr_ptr/rd_ptr present the address for the current cycle; the memory captures on the same edge.
- On an accepted op, the pointer increments on the edge and wraps DEPTH-1 -> 0 (not 2^MAIN_SIZE-1).

Count:
- +1 on write only, -1 on read only.
- Unchanged on simultaneous accepted write and read.
- Never exceeds DEPTH or goes below 0.

Simultaneous push & pop:
- Full: pop accepted, push rejected, overflow error raised (ERROR next cycle).
- Empty: push accepted, pop rejected, underflow error raised.
- Otherwise both are accepted.

Flags:
- All flags derive combinationally from registered count and latched thresholds, so they reflect an op one cycle after its edge.
- Threshold compare is unsigned CNT_SIZE. th_af > DEPTH means almost_full is never set; th_ae = 0 means almost_empty only when empty.

Error:
- Set on the edge following an overflow/underflow attempt; cleared only by reset.

Test Plan:
1. Reset then init pulse, th_af=3, th_ae=1 -> state goes 000, 001, 010; empty=1, almost_empty=1, count=0, wr_ptr=rd_ptr=0, write=read=0.
2. 4 consecutive pushes in IDLE -> write=1 each cycle; wr_ptr 0,1,2,3 then wraps to 0; count 1..4; almost_full at count=3; full=1 at count=4; state=ACTIVE.
3. From full, 4 pops -> read=1 each cycle; rd_ptr 0,1,2,3,0; count 3..0; almost_empty at count<=1; empty=1; state=IDLE.
4. count=2, push&pop held 6 cycles -> write=read=1 each cycle; count stays 2; both pointers advance with wrap (wr_ptr 2,3,0,1,2,3; rd_ptr 0,1,2,3,0,1).
5. Full, push alone -> write=0, next cycle error=1, state=100. Further push/pop produce write=read=0 and frozen pointers/count. Reset then returns state=000 and error=0.
6. Empty, pop alone -> read=0, error=1, state=ERROR. Separately, assert reset mid-stream at count=3 -> next cycle count=0, pointers=0, empty=1.
